bcd_code_tx: RTL and testbench
==============================

# bcd_code_tx

Serial transmitter for a two-digit BCD code. It is the sending end of the switch-entered digit check. It captures a high and a low BCD digit (the board's SW[7:4] / SW[3:0]) on a start request. It then shifts them out on a single line as a framed, MSB-first bit stream, with a configurable bit period. The line is intended for a GPIO pin or LEDR on the DE1-SoC top level, where a remote detector checks it for a matching code such as 26.

## Interface
- BIT_CYCLES, 4, clock cycles each frame bit is held on `tx`; legal range ≥1
- clk  input  1  system clock; all state changes on its rising edge
- reset_n  input  1  reset, synchronous, active-low
- start  input  1  transmit request; level-sampled; acted on only in IDLE
- digit_hi  input  4  high BCD digit, legal 0–9
- digit_lo  input  4  low BCD digit, legal 0–9
- tx  output  1  serial line, registered; idle level 1
- busy  output  1  high while a frame is in progress (START through STOP)
- done  output  1  one-cycle pulse after a frame's stop bit completes
- err  output  1  one-cycle pulse when a request is rejected for a non-BCD digit

## Operation
- States: IDLE, START, DATA, STOP, plus PARITY when compiled in.
- Reset (reset_n=0 at an edge): state IDLE, tx=1, busy=0, done=0, err=0, bit counter and cycle counter cleared.
- IDLE, start=1, both digits ≤9:
  - capture data = {digit_hi, digit_lo} into an 8-bit shift register;
  - go to START.
- IDLE, start=1, either digit >9:
  - err=1 for the following cycle;
  - stay in IDLE; tx stays 1; nothing is captured.
  - If the request is held, err repeats every cycle.
- START: tx=0 for BIT_CYCLES cycles, then DATA.
- DATA:
  - 8 bits, data[7] first (digit_hi[3]) through data[0] (digit_lo[0]);
  - each bit is held BIT_CYCLES cycles;
  - after bit 0 go to STOP, or to PARITY when enabled.
- STOP: tx=1 for BIT_CYCLES cycles, then IDLE with done=1 for exactly that first IDLE cycle.
- Captured data is unaffected by digit or start changes during busy. start is ignored while busy=1.
- The cycle counter is ⌈log2(BIT_CYCLES)⌉ bits wide (minimum 1) and wraps to 0 at BIT_CYCLES−1. The bit counter is 3 bits and runs 7→0.

## Timing
- Accept edge E0 (IDLE, start=1, valid digits). After E0: tx=0, busy=1.
- Frame bit i (i=0 is the start bit) drives tx from after edge E0+i·BIT_CYCLES until edge E0+(i+1)·BIT_CYCLES.
- Frame length N is 10·BIT_CYCLES cycles, or 11·BIT_CYCLES with parity.
- After edge E0+N: busy=0, tx=1, done=1 for one cycle.
- The earliest next accept is edge E0+N+1. A held start therefore gives back-to-back frames separated by exactly one idle cycle.
- done and err never assert in the same cycle. done never asserts together with busy=1.
- Reset mid-frame aborts the frame on that edge: tx=1 and busy=0 next cycle, and no done pulse is produced.
- reset_n=0 together with start=1 behaves as reset; the request is dropped.

## Configuration
- Macro: BCD_CODE_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA;
  - tx = XOR of data[7:0] (even parity over data plus parity bit) for BIT_CYCLES cycles;
  - frame is 11 bits.
- Undefined: no PARITY state; frame is 10 bits. All other behaviour is identical.

## Test plan
- BIT_CYCLES=4, digits 2,6, single start pulse:
  - tx = 0 | 0,0,1,0,0,1,1,0 | 1, each bit 4 cycles;
  - busy high 40 cycles, then done for 1 cycle;
  - with parity: parity bit 1 inserted before stop, 44 cycles.
- digit_lo=0xA, start pulse → err=1 for one cycle; tx stays 1, busy stays 0, done stays 0.
- reset_n=0 for one edge during DATA bit 3 of digits 2,6 → next cycle tx=1, busy=0, and no done. A subsequent start sends a full clean frame.
- start held high, digits 9,9, BIT_CYCLES=2 → two consecutive frames of data 0x99, separated by exactly one tx=1 idle cycle; done pulses twice.
- During a digits 2,6 frame, change the digits to 9,9 and pulse start → the transmitted frame is still 0x26, with no extra frame and no err.
- BIT_CYCLES=1, digits 0,0 → tx = 0, then eight 0s, then 1, one cycle each; done exactly 10 cycles after accept.

Source files
------------

// File: rtl/bcd_code_tx_if.sv
// Bus interface for bcd_code_tx: request/digit inputs and the serial line
// with its status flags. The master modport belongs to the requester, and the
// slave modport belongs to the transmitter.
interface bcd_code_tx_if;
  logic       start;
  logic [3:0] digit_hi;
  logic [3:0] digit_lo;
  logic       tx;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, digit_hi, digit_lo,
    input  tx, busy, done, err
  );

  modport slave (
    input  start, digit_hi, digit_lo,
    output tx, busy, done, err
  );
endinterface

// File: rtl/bcd_code_tx.sv
// bcd_code_tx: serial transmitter for a two-digit BCD code.
// A start request in IDLE captures {digit_hi, digit_lo}. The block then sends
// a start bit (0), 8 data bits MSB first, an optional even-parity bit and a
// stop bit (1). Each frame bit is held for BIT_CYCLES clocks.
// Optional feature: define BCD_CODE_TX_PARITY_EN to insert the parity bit.
module bcd_code_tx #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  bcd_code_tx_if.slave bus
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef BCD_CODE_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic bit_end;
  logic digits_ok;

  assign bit_end   = (cyc_q == CYC_LAST);
  assign digits_ok = (bus.digit_hi <= 4'd9) && (bus.digit_lo <= 4'd9);

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;

  // Next-state logic. tx is computed one cycle ahead so that the line is registered.
  // The data register rotates rather than shifts. After eight rotations it
  // holds the captured byte again, so the parity bit can be taken from it directly.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.start) begin
          if (digits_ok) begin
            data_d  = {bus.digit_hi, bus.digit_lo};
            state_d = S_START;
            cyc_d   = '0;
            bit_d   = 3'd7;
            tx_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = S_DATA;
          tx_d    = data_q[7];
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cyc_d  = '0;
          data_d = {data_q[6:0], data_q[7]};
          if (bit_q == 3'd0) begin
`ifdef BCD_CODE_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^data_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q - 3'd1;
            tx_d  = data_q[6];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

`ifdef BCD_CODE_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers. A synchronous reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_code_tx.sv
// Directed testbench for bcd_code_tx. It uses three instances with
// BIT_CYCLES of 4, 2 and 1.
module tb_bcd_code_tx;

`ifdef BCD_CODE_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_code_tx_if if4 ();
  bcd_code_tx_if if2 ();
  bcd_code_tx_if if1 ();

  bcd_code_tx #(.BIT_CYCLES(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
  bcd_code_tx #(.BIT_CYCLES(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  bcd_code_tx #(.BIT_CYCLES(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

  // Absolute time limit so that the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic [3:0] h, input logic [3:0] l);
    case (w)
      4: begin if4.start = s; if4.digit_hi = h; if4.digit_lo = l; end
      2: begin if2.start = s; if2.digit_hi = h; if2.digit_lo = l; end
      default: begin if1.start = s; if1.digit_hi = h; if1.digit_lo = l; end
    endcase
  endtask

  // Observed outputs packed as {tx, busy, done, err}
  function automatic logic [3:0] obs(input int w);
    case (w)
      4: return {if4.tx, if4.busy, if4.done, if4.err};
      2: return {if2.tx, if2.busy, if2.done, if2.err};
      default: return {if1.tx, if1.busy, if1.done, if1.err};
    endcase
  endfunction

  // Call this one delta after the accept edge. It checks every cycle of the
  // frame and then the done cycle. When poke is set, it changes the digits
  // and pulses start in the middle of the frame.
  task automatic expect_frame(input int w, input int bc, input logic [7:0] data,
                              input bit poke, input string nm);
    logic [3:0] o;
    int step;
    step = 0;
    for (int i = 0; i < NB; i++) begin
      logic eb;
      if (i == 0)            eb = 1'b0;
      else if (i <= 8)       eb = data[8-i];
      else if (i == NB - 1)  eb = 1'b1;
      else                   eb = ^data;
      for (int c = 0; c < bc; c++) begin
        o = obs(w);
        checks++;
        if (o !== {eb, 1'b1, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d: {tx,busy,done,err}=%b expected %b",
                   nm, i, c, o, {eb, 1'b1, 1'b0, 1'b0});
        end
        if (poke && step == 10) drive(w, 1'b1, 4'd9, 4'd9);
        if (poke && step == 11) drive(w, 1'b0, 4'd9, 4'd9);
        step++;
        tick();
      end
    end
    o = obs(w);
    checks++;
    if (o !== 4'b1010) begin
      errors++;
      $display("FAIL %s done-cycle: {tx,busy,done,err}=%b expected 1010", nm, o);
    end
  endtask

  task automatic test_reset();
    logic [3:0] o;
    reset_n = 1'b0;
    drive(4, 1'b0, 4'd0, 4'd0);
    drive(2, 1'b0, 4'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 4'd0);
    repeat (3) tick();
    foreach (o[k]) begin end
    for (int w = 1; w <= 4; w = w * 2) begin
      o = obs(w);
      checks++;
      if (o !== 4'b1000) begin
        errors++;
        $display("FAIL reset dut%0d: {tx,busy,done,err}=%b expected 1000", w, o);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_26();
    logic [3:0] o;
    drive(4, 1'b1, 4'd2, 4'd6);
    tick();
    drive(4, 1'b0, 4'd2, 4'd6);
    expect_frame(4, 4, 8'h26, 1'b0, "basic26");
    tick();
    o = obs(4);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL basic26 after-done: {tx,busy,done,err}=%b expected 1000", o);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] o;
    drive(4, 1'b1, 4'd2, 4'hA);
    tick();
    drive(4, 1'b0, 4'd2, 4'hA);
    o = obs(4);
    checks++;
    if (o !== 4'b1001) begin
      errors++;
      $display("FAIL invalid-lo: {tx,busy,done,err}=%b expected 1001", o);
    end
    tick();
    o = obs(4);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL invalid-lo clear: {tx,busy,done,err}=%b expected 1000", o);
    end
    // A held request with a bad high digit repeats err every cycle
    drive(4, 1'b1, 4'hF, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs(4);
      checks++;
      if (o !== 4'b1001) begin
        errors++;
        $display("FAIL invalid-held %0d: {tx,busy,done,err}=%b expected 1001", i, o);
      end
    end
    drive(4, 1'b0, 4'hF, 4'd3);
    tick();
    o = obs(4);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL invalid-held clear: {tx,busy,done,err}=%b expected 1000", o);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] o;
    bit seen;
    drive(4, 1'b1, 4'd2, 4'd6);
    tick();
    drive(4, 1'b0, 4'd2, 4'd6);
    repeat (21) tick();  // middle of frame bit 5, which is data bit 3
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    o = obs(4);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL reset-mid: {tx,busy,done,err}=%b expected 1000", o);
    end
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.tx !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset-mid quiet: activity seen=%0d expected 0", seen);
    end
    drive(4, 1'b1, 4'd2, 4'd6);
    tick();
    drive(4, 1'b0, 4'd2, 4'd6);
    expect_frame(4, 4, 8'h26, 1'b0, "after-reset26");
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] o;
    drive(2, 1'b1, 4'd9, 4'd9);
    tick();
    expect_frame(2, 2, 8'h99, 1'b0, "b2b-first");
    tick();
    expect_frame(2, 2, 8'h99, 1'b0, "b2b-second");
    drive(2, 1'b0, 4'd9, 4'd9);
    tick();
    o = obs(2);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL b2b end: {tx,busy,done,err}=%b expected 1000", o);
    end
  endtask

  task automatic test_digit_change();
    bit seen;
    drive(4, 1'b1, 4'd2, 4'd6);
    tick();
    drive(4, 1'b0, 4'd2, 4'd6);
    expect_frame(4, 4, 8'h26, 1'b1, "change26");
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (if4.busy !== 1'b0 || if4.err !== 1'b0 || if4.done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL change26 no-extra-frame: activity seen=%0d expected 0", seen);
    end
    drive(4, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic test_bc1();
    drive(1, 1'b1, 4'd0, 4'd0);
    tick();
    drive(1, 1'b0, 4'd0, 4'd0);
    expect_frame(1, 1, 8'h00, 1'b0, "bc1-00");
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_26();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    test_digit_change();
    test_bc1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
